// File: rtl/rv64_regfile_adder.sv
// Integer datapath core: 32 x XLEN register file (2 async read ports, 1 sync write port)
// plus a combinational XLEN-bit adder for addi results, jalr targets and store addresses.
module rv64_regfile_adder #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   raddr1,
    output logic [XLEN-1:0] rdata1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata2,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_comb begin
        regs_d = regs_q;
        if (we && (waddr != '0)) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Reads see the array state only, so a same-cycle write is visible after the edge.
    always_comb begin
        rdata1 = (raddr1 == '0) ? '0 : regs_q[raddr1];
        rdata2 = (raddr2 == '0) ? '0 : regs_q[raddr2];
    end

    assign result = src1 + src2;

endmodule

// File: tb/tb_rv64_regfile_adder.sv
// Randomized self-checking bench for rv64_regfile_adder against an array-based reference.
module tb_rv64_regfile_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  raddr1, raddr2, waddr;
    logic [63:0] rdata1, rdata2, wdata, src1, src2, result;
    logic        we;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] model [32];

    rv64_regfile_adder dut (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .raddr2 (raddr2),
        .rdata2 (rdata2),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .src1   (src1),
        .src2   (src2),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [63:0] model_read(input logic [4:0] a);
        return (a == 5'd0) ? 64'd0 : model[a];
    endfunction

    initial begin
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        raddr1 = '0; raddr2 = '0; src1 = '0; src2 = '0;
        #1;
        tick();
        rst = 1'b0;

        // Reset state of every address on both ports
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(31 - i);
            #1;
            check($sformatf("reset_rd1_x%0d", i), rdata1, 64'd0);
            check($sformatf("reset_rd2_x%0d", 31 - i), rdata2, 64'd0);
        end

        // x0 ignores writes
        we = 1'b1; waddr = 5'd0; wdata = 64'hDEAD;
        tick();
        we = 1'b0; raddr1 = 5'd0; raddr2 = 5'd0;
        #1;
        check("x0_rd1", rdata1, 64'd0);
        check("x0_rd2", rdata2, 64'd0);

        // Write x5; old value visible before the edge, new one after
        we = 1'b1; waddr = 5'd5; wdata = 64'h0123_4567_89AB_CDEF;
        raddr1 = 5'd5; raddr2 = 5'd5;
        #1;
        check("x5_before_edge", rdata1, 64'd0);
        tick();
        we = 1'b0;
        #1;
        check("x5_rd1", rdata1, 64'h0123_4567_89AB_CDEF);
        check("x5_rd2", rdata2, 64'h0123_4567_89AB_CDEF);

        // Write enable gating
        we = 1'b0; waddr = 5'd7; wdata = '1; raddr1 = 5'd7;
        tick();
        check("x7_we0", rdata1, 64'd0);
        we = 1'b1;
        tick();
        we = 1'b0;
        #1;
        check("x7_we1", rdata1, 64'hFFFF_FFFF_FFFF_FFFF);

        // Reset mid-run discards the concurrent write and clears everything
        we = 1'b1; waddr = 5'd3; wdata = 64'h55;
        tick();
        raddr1 = 5'd3;
        #1;
        check("x3_written", rdata1, 64'h55);
        rst = 1'b1; wdata = 64'hAA;
        tick();
        rst = 1'b0; we = 1'b0; raddr2 = 5'd5;
        #1;
        check("x3_after_rst", rdata1, 64'd0);
        check("x5_after_rst", rdata2, 64'd0);

        // Adder boundaries
        src1 = 64'hFFFF_FFFF_FFFF_FFFF; src2 = 64'd1;
        #1;
        check("add_wrap", result, 64'd0);
        src1 = 64'h8000_0000; src2 = 64'hFFFF_FFFF_FFFF_FFFC;
        #1;
        check("add_neg4", result, 64'h7FFF_FFFC);

        // Random phase against the array model
        for (int i = 0; i < 32; i++) model[i] = 64'd0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            rst    = ($urandom_range(0, 199) == 0);
            we     = $urandom_range(0, 1) == 1;
            waddr  = 5'($urandom_range(0, 31));
            wdata  = rand64();
            raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            raddr2 = ($urandom_range(0, 3) == 0) ? raddr1 : 5'($urandom_range(0, 31));
            src1   = rand64();
            src2   = ($urandom_range(0, 7) == 0) ? (64'd0 - src1 + 64'($urandom_range(0, 3))) : rand64();
            #1;
            check($sformatf("rnd_rd1_c%0d", cyc), rdata1, model_read(raddr1));
            check($sformatf("rnd_rd2_c%0d", cyc), rdata2, model_read(raddr2));
            check($sformatf("rnd_add_c%0d", cyc), result, src1 + src2);
            tick();
            if (rst) begin
                for (int i = 0; i < 32; i++) model[i] = 64'd0;
            end else if (we && waddr != 5'd0) begin
                model[waddr] = wdata;
            end
        end

        rst = 1'b0; we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(i);
            #1;
            check($sformatf("final_rd1_x%0d", i), rdata1, model_read(5'(i)));
            check($sformatf("final_rd2_x%0d", i), rdata2, model_read(5'(i)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
